// File: rtl/rename_ckpt.sv
// rename_ckpt: register-rename stage. Map table plus circular free list,
// wrapping ROB tag, and NUM_CKPT independent branch checkpoints.
module rename_ckpt #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 128,
    parameter int ROB_DEPTH = 16,
    parameter int NUM_CKPT  = 4,
    parameter int PAYLOAD_W = 64,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int TW = $clog2(ROB_DEPTH),
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [AW-1:0]        in_rs1,
    input  logic [AW-1:0]        in_rs2,
    input  logic [AW-1:0]        in_rd,
    input  logic [6:0]           in_opcode,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 commit_valid,
    input  logic [PW-1:0]        commit_preg,
    input  logic                 br_resolve,
    input  logic [CW-1:0]        br_tag,
    input  logic                 br_mispredict,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [PW-1:0]        out_ps1,
    output logic [PW-1:0]        out_ps2,
    output logic [PW-1:0]        out_pd_new,
    output logic [PW-1:0]        out_pd_old,
    output logic [TW-1:0]        out_rob_tag,
    output logic [CW-1:0]        out_br_tag,
    output logic [6:0]           out_opcode,
    output logic [PAYLOAD_W-1:0] out_payload
);

    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Free-list pointers: [PW] is the wrap bit, [PW-1:0] the slot index.
    logic [PW-1:0]       map    [ARCH_REGS];
    logic [PW-1:0]       fl     [FL_DEPTH];
    logic [PW:0]         rd_ptr;
    logic [PW:0]         wr_ptr;
    logic [TW-1:0]       tag;
    logic [NUM_CKPT-1:0] live;
    // younger[j][k]: checkpoint k was allocated while j was live.
    logic [NUM_CKPT-1:0] younger [NUM_CKPT];

    logic [PW-1:0]       ck_map [NUM_CKPT][ARCH_REGS];
    logic [PW:0]         ck_rd  [NUM_CKPT];
    logic [TW-1:0]       ck_tag [NUM_CKPT];

    logic                writes, is_br, fl_empty, ckpt_full, fire, push;
    logic                flush, resolve_ok;
    logic [CW-1:0]       free_idx;
    logic                found;
    logic [NUM_CKPT-1:0] live_keep;

    function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
        if (p[PW-1:0] == PW'(FL_DEPTH - 1))
            return {~p[PW], {PW{1'b0}}};
        return {p[PW], p[PW-1:0] + PW'(1)};
    endfunction

    assign writes     = (in_opcode != OP_STORE) && (in_opcode != OP_BRANCH) && (in_rd != '0);
    assign is_br      = (in_opcode == OP_BRANCH);
    assign fl_empty   = (rd_ptr == wr_ptr);
    assign ckpt_full  = &live;
    assign ready_in   = (ready_out || !valid_out) && !(writes && fl_empty)
                        && !(is_br && ckpt_full) && !(br_resolve && br_mispredict);
    assign fire       = valid_in && ready_in;
    assign push       = commit_valid && (commit_preg != '0);
    assign flush      = br_resolve && br_mispredict && live[br_tag];
    assign resolve_ok = br_resolve && !br_mispredict && live[br_tag];

    // Lowest-index free checkpoint, and the live set after a correct resolve.
    always_comb begin
        free_idx  = '0;
        found     = 1'b0;
        live_keep = live;
        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            if (!live[i] && !found) begin
                free_idx = CW'(i);
                found    = 1'b1;
            end
        end
        if (resolve_ok)
            live_keep[br_tag] = 1'b0;
    end

    // Rename state, checkpoint bookkeeping and the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) map[i] <= PW'(i);
            for (int unsigned i = 0; i < FL_DEPTH; i++)  fl[i]  <= PW'(ARCH_REGS + i);
            for (int unsigned i = 0; i < NUM_CKPT; i++)  younger[i] <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= {1'b1, {PW{1'b0}}};
            tag         <= '0;
            live        <= '0;
            valid_out   <= 1'b0;
            out_ps1     <= '0;
            out_ps2     <= '0;
            out_pd_new  <= '0;
            out_pd_old  <= '0;
            out_rob_tag <= '0;
            out_br_tag  <= '0;
            out_opcode  <= '0;
            out_payload <= '0;
        end else begin
            // Commit push is independent of recovery: freed registers stay freed.
            if (push) begin
                fl[wr_ptr[PW-1:0]] <= commit_preg;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (flush) begin
                map       <= ck_map[br_tag];
                rd_ptr    <= ck_rd[br_tag];
                tag       <= ck_tag[br_tag];
                valid_out <= 1'b0;
                for (int unsigned k = 0; k < NUM_CKPT; k++) begin
                    if (CW'(k) == br_tag || younger[br_tag][k]) begin
                        live[k] <= 1'b0;
                        for (int unsigned j = 0; j < NUM_CKPT; j++) younger[j][k] <= 1'b0;
                    end
                end
            end else begin
                if (resolve_ok) begin
                    live[br_tag] <= 1'b0;
                    for (int unsigned j = 0; j < NUM_CKPT; j++) younger[j][br_tag] <= 1'b0;
                end
                if (fire) begin
                    out_ps1     <= map[in_rs1];
                    out_ps2     <= map[in_rs2];
                    out_pd_new  <= writes ? fl[rd_ptr[PW-1:0]] : '0;
                    out_pd_old  <= writes ? map[in_rd] : '0;
                    out_rob_tag <= tag;
                    out_br_tag  <= is_br ? free_idx : '0;
                    out_opcode  <= in_opcode;
                    out_payload <= in_payload;
                    tag         <= tag + TW'(1);
                    if (writes) begin
                        map[in_rd] <= fl[rd_ptr[PW-1:0]];
                        rd_ptr     <= ptr_inc(rd_ptr);
                    end
                    if (is_br) begin
                        live[free_idx]    <= 1'b1;
                        younger[free_idx] <= '0;
                        for (int unsigned j = 0; j < NUM_CKPT; j++)
                            younger[j][free_idx] <= live_keep[j];
                    end
                end
                if (fire)
                    valid_out <= 1'b1;
                else if (ready_out)
                    valid_out <= 1'b0;
            end
        end
    end

    // Checkpoint snapshot: pre-rename map, read pointer, tag after the branch.
    always_ff @(posedge clk) begin
        if (fire && is_br) begin
            ck_map[free_idx] <= map;
            ck_rd[free_idx]  <= rd_ptr;
            ck_tag[free_idx] <= tag + TW'(1);
        end
    end

endmodule

// File: tb/tb_rename_ckpt.sv
// tb_rename_ckpt: directed vector table plus hand-written multi-cycle sequences.
module tb_rename_ckpt;

    localparam int ADD = 7'h33;
    localparam int BR  = 7'h63;
    localparam int ST  = 7'h23;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [6:0]  in_opcode = '0;
    logic [63:0] in_payload = '0;
    logic        commit_valid = 1'b0;
    logic [6:0]  commit_preg = '0;
    logic        br_resolve = 1'b0;
    logic [1:0]  br_tag = '0;
    logic        br_mispredict = 1'b0;
    logic        valid_out;
    logic        ready_out = 1'b1;
    logic [6:0]  out_ps1, out_ps2, out_pd_new, out_pd_old;
    logic [3:0]  out_rob_tag;
    logic [1:0]  out_br_tag;
    logic [6:0]  out_opcode;
    logic [63:0] out_payload;

    int n_vec = 0;
    int n_bad = 0;

    rename_ckpt #(
        .ARCH_REGS(32), .PHYS_REGS(128), .ROB_DEPTH(16), .NUM_CKPT(4), .PAYLOAD_W(64)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_opcode(in_opcode),
        .in_payload(in_payload), .commit_valid(commit_valid), .commit_preg(commit_preg),
        .br_resolve(br_resolve), .br_tag(br_tag), .br_mispredict(br_mispredict),
        .valid_out(valid_out), .ready_out(ready_out), .out_ps1(out_ps1), .out_ps2(out_ps2),
        .out_pd_new(out_pd_new), .out_pd_old(out_pd_old), .out_rob_tag(out_rob_tag),
        .out_br_tag(out_br_tag), .out_opcode(out_opcode), .out_payload(out_payload)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v, op, rs1, rs2, rd, rdy, br, bt, mp;
        int e_rin, e_vo, e_ps1, e_ps2, e_pdn, e_pdo, e_tag, e_bt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input int v, op, rs1, rs2, rd, rdy, br, bt, mp,
                                input int e_rin, e_vo, e_ps1, e_ps2, e_pdn, e_pdo, e_tag, e_bt);
        vec_t t;
        t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rdy = rdy;
        t.br = br; t.bt = bt; t.mp = mp; t.e_rin = e_rin; t.e_vo = e_vo;
        t.e_ps1 = e_ps1; t.e_ps2 = e_ps2; t.e_pdn = e_pdn; t.e_pdo = e_pdo;
        t.e_tag = e_tag; t.e_bt = e_bt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int op, input int rs1, input int rs2,
                         input int rd, input int rdy);
        valid_in  = v[0];
        in_opcode = op[6:0];
        in_rs1    = rs1[4:0];
        in_rs2    = rs2[4:0];
        in_rd     = rd[4:0];
        ready_out = rdy[0];
    endtask

    task automatic do_reset;
        drive(0, ADD, 0, 0, 0, 1);
        br_resolve = 1'b0; br_mispredict = 1'b0; commit_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_pd_new", out_pd_new, 0);
        chk("rst_rob_tag", out_rob_tag, 0);
        chk("rst_ps1", out_ps1, 0);
        chk("rst_ready_in", ready_in, 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        logic [63:0] pay;
        pay = 64'hC0DE_0000_0000_0000 | 64'(idx);
        drive(t.v, t.op, t.rs1, t.rs2, t.rd, t.rdy);
        in_payload    = pay;
        br_resolve    = t.br[0];
        br_tag        = t.bt[1:0];
        br_mispredict = t.mp[0];
        #1 chk("vec_ready_in", ready_in, 64'(t.e_rin));
        tick;
        br_resolve = 1'b0; br_mispredict = 1'b0;
        chk("vec_valid_out", valid_out, 64'(t.e_vo));
        if (t.e_vo != 0) begin
            chk("vec_ps1", out_ps1, 64'(t.e_ps1));
            chk("vec_ps2", out_ps2, 64'(t.e_ps2));
            chk("vec_pd_new", out_pd_new, 64'(t.e_pdn));
            chk("vec_pd_old", out_pd_old, 64'(t.e_pdo));
            chk("vec_rob_tag", out_rob_tag, 64'(t.e_tag));
            chk("vec_br_tag", out_br_tag, 64'(t.e_bt));
            chk("vec_opcode", out_opcode, 64'(t.op));
            chk("vec_payload", out_payload, pay);
        end
    endtask

    initial begin
        //          v  op   rs1 rs2 rd rdy br bt mp  rin vo ps1 ps2 pdn pdo tag bt
        tbl[0]  = mk(1, ADD, 0, 0, 1, 1, 0, 0, 0,  1, 1,  0,  0, 32,  1,  0, 0);
        tbl[1]  = mk(1, ADD, 1, 2, 2, 1, 0, 0, 0,  1, 1, 32,  2, 33,  2,  1, 0);
        tbl[2]  = mk(1, ADD, 2, 0, 3, 1, 0, 0, 0,  1, 1, 33,  0, 34,  3,  2, 0);
        tbl[3]  = mk(1, ST,  3, 1, 5, 1, 0, 0, 0,  1, 1, 34, 32,  0,  0,  3, 0);
        tbl[4]  = mk(1, ADD, 1, 0, 0, 1, 0, 0, 0,  1, 1, 32,  0,  0,  0,  4, 0);
        tbl[5]  = mk(1, ADD, 1, 0, 1, 1, 0, 0, 0,  1, 1, 32,  0, 35, 32,  5, 0);
        tbl[6]  = mk(1, BR,  1, 2, 0, 1, 0, 0, 0,  1, 1, 35, 33,  0,  0,  6, 0);
        tbl[7]  = mk(1, ADD, 1, 0, 1, 1, 0, 0, 0,  1, 1, 35,  0, 36, 35,  7, 0);
        tbl[8]  = mk(1, ADD, 1, 0, 2, 1, 0, 0, 0,  1, 1, 36,  0, 37, 33,  8, 0);
        tbl[9]  = mk(1, ADD, 0, 0, 1, 1, 1, 0, 1,  0, 0,  0,  0,  0,  0,  0, 0);
        tbl[10] = mk(1, ADD, 1, 2, 1, 1, 0, 0, 0,  1, 1, 35, 33, 36, 35,  7, 0);
        tbl[11] = mk(0, ADD, 0, 0, 0, 1, 0, 0, 0,  1, 0,  0,  0,  0,  0,  0, 0);
        tbl[12] = mk(1, BR,  1, 0, 0, 1, 0, 0, 0,  1, 1, 36,  0,  0,  0,  8, 0);
        tbl[13] = mk(1, ADD, 2, 0, 2, 1, 1, 0, 0,  1, 1, 33,  0, 37, 33,  9, 0);
        tbl[14] = mk(0, ADD, 0, 0, 0, 1, 1, 0, 1,  0, 0,  0,  0,  0,  0,  0, 0);
        tbl[15] = mk(1, ADD, 2, 0, 2, 1, 0, 0, 0,  1, 1, 37,  0, 38, 37, 10, 0);

        do_reset;
        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // Free-list exhaustion, tag wrap, commit refill without bypass.
        do_reset;
        for (int i = 0; i < 96; i++) begin
            drive(1, ADD, 1, 0, 1, 1);
            #1 chk("fl_ready_in", ready_in, 1);
            tick;
            chk("fl_pd_new", out_pd_new, 64'(32 + i));
            chk("fl_rob_tag", out_rob_tag, 64'(i % 16));
            chk("fl_pd_old", out_pd_old, (i == 0) ? 64'd1 : 64'(31 + i));
        end
        drive(1, ADD, 1, 0, 1, 1);
        commit_valid = 1'b1; commit_preg = 7'd5;
        #1 chk("fl_empty_stall", ready_in, 0);
        tick;
        commit_valid = 1'b0;
        chk("fl_stall_vo", valid_out, 0);
        #1 chk("fl_refill_ready", ready_in, 1);
        tick;
        chk("fl_reuse_pd_new", out_pd_new, 5);
        chk("fl_reuse_pd_old", out_pd_old, 127);
        chk("fl_reuse_tag", out_rob_tag, 0);

        // Checkpoint exhaustion, correct resolve reuse, nested mispredict.
        do_reset;
        for (int k = 0; k < 4; k++) begin
            drive(1, BR, 0, 0, 0, 1);
            #1 chk("ck_ready_in", ready_in, 1);
            tick;
            chk("ck_br_tag", out_br_tag, 64'(k));
            chk("ck_rob_tag", out_rob_tag, 64'(k));
        end
        drive(1, BR, 0, 0, 0, 1);
        #1 chk("ck_full_stall", ready_in, 0);
        tick;
        chk("ck_full_vo", valid_out, 0);
        br_resolve = 1'b1; br_tag = 2'd1; br_mispredict = 1'b0;
        #1 chk("ck_resolve_cycle_ready", ready_in, 0);
        tick;
        br_resolve = 1'b0;
        #1 chk("ck_freed_ready", ready_in, 1);
        tick;
        chk("ck_reuse_vo", valid_out, 1);
        chk("ck_reuse_br_tag", out_br_tag, 1);
        chk("ck_reuse_rob_tag", out_rob_tag, 4);
        br_resolve = 1'b1; br_tag = 2'd0; br_mispredict = 1'b1;
        #1 chk("ck_mp_ready", ready_in, 0);
        tick;
        br_resolve = 1'b0; br_mispredict = 1'b0;
        chk("ck_mp_vo", valid_out, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, BR, 0, 0, 0, 1);
            tick;
            chk("ck_after_mp_br_tag", out_br_tag, 64'(k));
            chk("ck_after_mp_rob_tag", out_rob_tag, 64'(1 + k));
        end

        // Output hold under backpressure, mispredict during hold, async reset.
        do_reset;
        drive(1, BR, 0, 0, 0, 1);
        tick;
        chk("hold_br_tag", out_br_tag, 0);
        drive(1, ADD, 0, 0, 1, 1);
        tick;
        chk("hold_pd_new0", out_pd_new, 32);
        for (int r = 0; r < 2; r++) begin
            drive(1, ADD, 0, 0, 2, 0);
            #1 chk("hold_ready_in", ready_in, 0);
            tick;
            chk("hold_vo", valid_out, 1);
            chk("hold_pd_new", out_pd_new, 32);
            chk("hold_pd_old", out_pd_old, 1);
            chk("hold_rob_tag", out_rob_tag, 1);
        end
        br_resolve = 1'b1; br_tag = 2'd0; br_mispredict = 1'b1;
        tick;
        br_resolve = 1'b0; br_mispredict = 1'b0;
        chk("hold_mp_vo", valid_out, 0);
        drive(1, ADD, 0, 0, 1, 1);
        tick;
        chk("hold_after_pd_new", out_pd_new, 32);
        chk("hold_after_pd_old", out_pd_old, 1);
        chk("hold_after_tag", out_rob_tag, 1);
        drive(1, ADD, 0, 0, 3, 1);
        tick;
        chk("pre_reset_pd_new", out_pd_new, 33);
        do_reset;
        drive(1, ADD, 0, 0, 1, 1);
        tick;
        chk("post_reset_pd_new", out_pd_new, 32);
        chk("post_reset_pd_old", out_pd_old, 1);
        chk("post_reset_tag", out_rob_tag, 0);
        drive(0, ADD, 0, 0, 0, 1);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
